// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // sclk cycles per bit for a given clock and line rate
  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus an edge-detect flop.
// All flops reset high so an idle line never produces a spurious falling edge.
module rx_sync (
  input  logic sclk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // shift the raw line through the chain; [1] is the synced value, [2] its delay
  always_comb begin
    sync_d = {sync_q[1:0], rx};
  end

  // synchronizer / edge-capture registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Good bytes appear on po_data with a one-cycle po_flag; framing and parity
// errors raise their own one-cycle strobes and leave po_data untouched.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(BAUD_CNT_MAX / 2 - 1);

  logic rx_s;
  logic fall;

  rx_sync u_rx_sync (
    .sclk  (sclk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   po_data_q, po_data_d;
  logic                   po_flag_q, po_flag_d;
  logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad_q, parity_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic at_sample;
  assign at_sample = (cnt_q == CNT_SAMPLE);

  // next-state, baud timing, bit assembly and strobe generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    po_data_d   = po_data_q;
    po_flag_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != ST_IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        // a start bit that is high again at midpoint was a glitch
        if (at_sample) begin
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_sample) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        // even parity: data bits XOR parity bit must be zero
        if (at_sample) begin
          parity_bad_d = ^{shift_q, rx_s};
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // back to IDLE at the stop midpoint to catch the next start early
        if (at_sample) begin
          if (rx_s) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              po_data_d = shift_q;
              po_flag_d = 1'b1;
            end
`else
            po_data_d = shift_q;
            po_flag_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // a held-low break must release before a new start is accepted
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      po_data_q   <= '0;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      po_data_q   <= po_data_d;
      po_flag_q   <= po_flag_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized self-checking bench for uart_rx_byte (CLK_FREQ=160, BAUD=10).
// Honours UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx_byte;

  localparam int BIT_T = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  localparam longint LAT = longint'(3 + NBITS * BIT_T + BIT_T / 2);

  localparam int EV_FLAG = 1;
  localparam int EV_FERR = 2;
  localparam int EV_PERR = 3;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       parity_err;

  int vectors = 0;
  int miscompares = 0;
  longint cyc = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     at;
  } ev_t;
  ev_t evq[$];
  logic prev_any = 1'b0;

  uart_rx_byte #(
    .CLK_FREQ (160),
    .BAUD     (10)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .rx         (rx),
    .po_data    (po_data),
    .po_flag    (po_flag),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // strobe monitor: record every strobe, enforce one-hot and single-cycle
  always @(negedge sclk) begin
    logic any;
    ev_t  e;
    any = po_flag | frame_err | parity_err;
    if (any) begin
      check("strobe_onehot", 64'($countones({po_flag, frame_err, parity_err})), 64'd1);
      check("strobe_one_cycle", 64'(prev_any), 64'd0);
      e.kind = po_flag ? EV_FLAG : (frame_err ? EV_FERR : EV_PERR);
      e.data = po_data;
      e.at   = cyc;
      evq.push_back(e);
    end
    prev_any = any;
  end

  // drive one frame starting at the current negedge; line left at stop level
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            output longint t0);
    rx = 1'b0;
    t0 = cyc;
    repeat (BIT_T) @(negedge sclk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_T) @(negedge sclk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (BIT_T) @(negedge sclk);
`else
    if (par) begin end
`endif
    rx = stop;
    repeat (BIT_T) @(negedge sclk);
  endtask

  // reference outcome of one frame, compared with what the monitor saw
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic stop,
                              input logic par, input longint t0);
    int  kind;
    ev_t e;
    if (!stop) kind = EV_FERR;
`ifdef UART_RX_PARITY_EN
    else if ((^d) != par) kind = EV_PERR;
`else
    else if (par && 1'b0) kind = EV_PERR;
`endif
    else kind = EV_FLAG;
    check({tag, "_events"}, 64'(evq.size()), 64'd1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      check({tag, "_kind"}, 64'(e.kind), 64'(kind));
      check({tag, "_latency"}, e.at - t0, LAT);
      if (kind == EV_FLAG) last_good = d;
      check({tag, "_data"}, 64'(e.data), 64'(last_good));
    end
    check({tag, "_po_data"}, 64'(po_data), 64'(last_good));
    evq.delete();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                           input logic par);
    longint t0;
    send_frame(d, stop, par, t0);
    expect_frame(tag, d, stop, par, t0);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 64'(evq.size()), 64'd0);
    evq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;
    int         gap;

    repeat (3) @(negedge sclk);
    check("rst_po_data", 64'(po_data), 64'h00);
    check("rst_po_flag", 64'(po_flag), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_parity_err", 64'(parity_err), 64'd0);
    rst_n = 1'b1;
    repeat (2 * BIT_T) @(negedge sclk);
    check_quiet("idle_quiet");

    // single byte with exact latency
    run_frame("a5", 8'hA5, 1'b1, ^8'hA5);

    // back-to-back frames with one stop bit
    run_frame("b2b_00", 8'h00, 1'b1, ^8'h00);
    run_frame("b2b_ff", 8'hFF, 1'b1, ^8'hFF);
    rx = 1'b1;
    repeat (BIT_T) @(negedge sclk);

    // short low glitch must be rejected
    rx = 1'b0;
    repeat (4) @(negedge sclk);
    rx = 1'b1;
    repeat (3 * BIT_T) @(negedge sclk);
    check_quiet("glitch_quiet");
    run_frame("after_glitch", 8'h3C, 1'b1, ^8'h3C);

    // framing error followed by a long break
    run_frame("ferr_55", 8'h55, 1'b0, ^8'h55);
    repeat (40 * BIT_T) @(negedge sclk);
    rx = 1'b1;
    repeat (2 * BIT_T) @(negedge sclk);
    check_quiet("break_quiet");
    run_frame("after_break", 8'h12, 1'b1, ^8'h12);

    // reset after four data bits of a frame
    rx = 1'b0;
    repeat (BIT_T) @(negedge sclk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BIT_T) @(negedge sclk);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge sclk);
    check("midrst_po_data", 64'(po_data), 64'h00);
    check("midrst_po_flag", 64'(po_flag), 64'd0);
    check("midrst_frame_err", 64'(frame_err), 64'd0);
    check("midrst_parity_err", 64'(parity_err), 64'd0);
    last_good = 8'h00;
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    repeat (12 * BIT_T) @(negedge sclk);
    check_quiet("midrst_quiet");
    run_frame("after_rst", 8'h81, 1'b1, ^8'h81);

`ifdef UART_RX_PARITY_EN
    run_frame("par_good", 8'h07, 1'b1, 1'b1);
    run_frame("par_bad", 8'h07, 1'b1, 1'b0);
`endif

    // randomized frames with occasional framing and parity errors
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      par  = ^d;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 3) == 0) par = ~par;
`endif
      run_frame("rand", d, stop, par);
      rx  = 1'b1;
      gap = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
      repeat (gap) @(negedge sclk);
    end

    repeat (2 * BIT_T) @(negedge sclk);
    check_quiet("final_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
